// File: rtl/sync_mod_counter.sv
// Fully registered up/down modulo counter (0..MAX_VAL) with parallel load and wrap pulse.
// Optional registered Gray-coded output enabled by defining SYNC_MOD_COUNTER_GRAY_EN.
module sync_mod_counter #(
  parameter int unsigned           WIDTH   = 4,
  parameter logic [WIDTH-1:0]      MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic [WIDTH-1:0] count_gray
);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // Terminal tests happen before any +1/-1, so the WIDTH-bit sum never overflows.
  always_comb begin
    count_nxt = count_q;
    wrap_nxt  = 1'b0;
    if (load) begin
      count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q == MAX_VAL) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_nxt = MAX_VAL;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

`ifdef SYNC_MOD_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray_q;

  // Encoded from the next count so the Gray value lines up with count in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_nxt ^ (count_nxt >> 1);
    end
  end

  assign count_gray = gray_q;
`else
  assign count_gray = '0;
`endif

endmodule

// File: tb/tb_sync_mod_counter.sv
// Self-checking bench: two counters (MAX_VAL=9 and 15) against a modular-arithmetic model,
// plus directed scenarios with literal expectations.
module tb_sync_mod_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] count9, gray9, count15, gray15;
  logic         wrap9, wrap15;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  sync_mod_counter #(.WIDTH(W), .MAX_VAL(4'd9)) dut9 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count9), .wrap(wrap9), .count_gray(gray9)
  );

  sync_mod_counter #(.WIDTH(W), .MAX_VAL(4'd15)) dut15 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count15), .wrap(wrap15), .count_gray(gray15)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: wrap arithmetic via modulo, no register-level structure.
  int unsigned maxs [2] = '{9, 15};
  int unsigned m_cnt [2];
  bit          m_wrap [2];
  bit          m_valid = 1'b0;
  bit          m_stepped = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_cnt[i]  <= 0;
        m_wrap[i] <= 1'b0;
      end else if (load) begin
        m_cnt[i]  <= (int'(load_val) > maxs[i]) ? maxs[i] : int'(load_val);
        m_wrap[i] <= 1'b0;
      end else if (en) begin
        if (up) begin
          m_cnt[i]  <= (m_cnt[i] + 1) % (maxs[i] + 1);
          m_wrap[i] <= (m_cnt[i] == maxs[i]);
        end else begin
          m_cnt[i]  <= (m_cnt[i] + maxs[i]) % (maxs[i] + 1);
          m_wrap[i] <= (m_cnt[i] == 0);
        end
      end else begin
        m_wrap[i] <= 1'b0;
      end
    end
    if (!rst) m_valid <= 1'b1;
    m_stepped <= rst && !load && en && m_valid;
  end

  function automatic int unsigned exp_gray(input int unsigned c);
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    return c ^ (c >> 1);
`else
    return 0;
`endif
  endfunction

  logic [W-1:0] prev_gray15;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("count9", count9, m_cnt[0]);
      chk("wrap9", wrap9, m_wrap[0]);
      chk("gray9", gray9, exp_gray(m_cnt[0]));
      chk("count15", count15, m_cnt[1]);
      chk("wrap15", wrap15, m_wrap[1]);
      chk("gray15", gray15, exp_gray(m_cnt[1]));
`ifdef SYNC_MOD_COUNTER_GRAY_EN
      if (m_stepped) chk("gray15_hamming", $countones(gray15 ^ prev_gray15), 1);
`endif
      prev_gray15 = gray15;
    end
  end

  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [W-1:0] lv);
    @(negedge clk);
    #1;
    rst = r; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  int unsigned up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int unsigned dn_seq [4]  = '{1, 0, 9, 8};
  int unsigned tg_seq [4]  = '{6, 5, 6, 5};

  initial begin
    // Reset then up-count
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reset_count", count9, 0);
    chk("reset_wrap", wrap9, 0);
    chk("reset_gray", gray15, 0);
    foreach (up_seq[i]) begin
      step(1, 1, 1, 0, 0);
      chk("up_count", count9, up_seq[i]);
      chk("up_wrap", wrap9, up_seq[i] == 0);
    end
    chk("up_count15", count15, 12);
`ifdef SYNC_MOD_COUNTER_GRAY_EN
    chk("gray15_lit", gray15, 10);
`else
    chk("gray15_lit", gray15, 0);
`endif

    // Down-count across zero
    step(1, 0, 0, 1, 2);
    chk("load2", count9, 2);
    foreach (dn_seq[i]) begin
      step(1, 1, 0, 0, 0);
      chk("down_count", count9, dn_seq[i]);
      chk("down_wrap", wrap9, dn_seq[i] == 9);
    end

    // Load priority and saturation
    step(1, 1, 1, 1, 13);
    chk("sat_count", count9, 9);
    chk("sat_wrap", wrap9, 0);
    chk("sat_count15", count15, 13);
    step(1, 1, 1, 0, 0);
    chk("after_sat_count", count9, 0);
    chk("after_sat_wrap", wrap9, 1);

    // Hold then direction toggling
    step(1, 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0);
      chk("hold_count", count9, 5);
      chk("hold_wrap", wrap9, 0);
    end
    foreach (tg_seq[i]) begin
      step(1, 1, (i % 2 == 0), 0, 0);
      chk("toggle_count", count9, tg_seq[i]);
    end

    // Reset overrides load mid-count
    step(1, 0, 0, 1, 7);
    step(0, 1, 1, 1, 3);
    chk("midrst_count", count9, 0);
    chk("midrst_wrap", wrap9, 0);
    step(1, 1, 1, 0, 0);
    chk("resume_count", count9, 1);

    // Free-run full-range counter through wraps
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);
    chk("freerun_count15", count15, 4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(63) != 0, $urandom_range(3) != 0, 1'($urandom),
           $urandom_range(7) == 0, 4'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
